// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - two-key debounced pulse generator; define KEY_PULSE_AUTO_REPEAT_EN for auto-repeat
// Each key: 2-flop synchronizer, debounce counter, then a small FSM that emits request pulses.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_faster_n,
  input  logic       key_slower_n,
  output logic       faster,
  output logic       slower,
  output logic [1:0] held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef KEY_PULSE_AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;
`else
  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } state_e;
`endif

  // index 1 = faster key, index 0 = slower key, matching held
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      key_s;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      lvl_q, lvl_d;
  state_e          state_q [2];
  state_e          state_d [2];
  logic [1:0]      pulse_req;
  logic            both_held_d;
  logic            faster_q, faster_d;
  logic            slower_q, slower_d;

`ifdef KEY_PULSE_AUTO_REPEAT_EN
  logic [RP_W-1:0] rp_cnt_q [2];
  logic [RP_W-1:0] rp_cnt_d [2];
  logic [1:0]      expire;
`endif

  assign key_s = ~sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {key_faster_n, key_slower_n};
      sync2_q <= sync1_q;
    end
  end

  // Level toggles on the edge where the differing run would reach DEBOUNCE_CYCLES.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (key_s[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      lvl_q <= lvl_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

`ifdef KEY_PULSE_AUTO_REPEAT_EN
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      expire[i] = (rp_cnt_q[i] == RP_W'(1));
    end
  end
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state_q[i] <= ST_RELEASED;
`ifdef KEY_PULSE_AUTO_REPEAT_EN
        rp_cnt_q[i] <= '0;
`endif
      end else begin
        state_q[i] <= state_d[i];
`ifdef KEY_PULSE_AUTO_REPEAT_EN
        rp_cnt_q[i] <= rp_cnt_d[i];
`endif
      end
    end
  end

  // Release is checked before expiry so a simultaneous release cancels the pulse.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_RELEASED: begin
          if (lvl_q[i]) state_d[i] = ST_PRESSED;
        end
        ST_PRESSED: begin
          if (!lvl_q[i]) state_d[i] = ST_RELEASED;
`ifdef KEY_PULSE_AUTO_REPEAT_EN
          else if (expire[i]) state_d[i] = ST_REPEATING;
        end
        ST_REPEATING: begin
          if (!lvl_q[i]) state_d[i] = ST_RELEASED;
`endif
        end
        default: state_d[i] = ST_RELEASED;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pulse_req[i] = 1'b0;
`ifdef KEY_PULSE_AUTO_REPEAT_EN
      rp_cnt_d[i] = (rp_cnt_q[i] != '0) ? rp_cnt_q[i] - 1'b1 : '0;
`endif
      case (state_q[i])
        ST_RELEASED: begin
          if (lvl_q[i]) begin
            pulse_req[i] = 1'b1;
`ifdef KEY_PULSE_AUTO_REPEAT_EN
            rp_cnt_d[i] = RP_W'(REPEAT_DELAY);
`endif
          end
        end
`ifdef KEY_PULSE_AUTO_REPEAT_EN
        ST_PRESSED, ST_REPEATING: begin
          if (!lvl_q[i]) begin
            rp_cnt_d[i] = '0;
          end else if (expire[i]) begin
            pulse_req[i] = 1'b1;
            rp_cnt_d[i] = RP_W'(REPEAT_RATE);
          end
        end
`endif
        default: pulse_req[i] = 1'b0;
      endcase
    end
  end

  // Suppression looks at held as it will be in the cycle the pulse is visible.
  always_comb begin
    both_held_d = lvl_d[1] & lvl_d[0];
    faster_d    = pulse_req[1] & ~both_held_d;
    slower_d    = pulse_req[0] & ~both_held_d & ~pulse_req[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      faster_q <= 1'b0;
      slower_q <= 1'b0;
    end else begin
      faster_q <= faster_d;
      slower_q <= slower_d;
    end
  end

  assign faster = faster_q;
  assign slower = slower_q;
  assign held   = lvl_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - randomized and directed bench for key_pulse_gen against a timestamp model
module tb_key_pulse_gen;
  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kf_n = 1'b1;
  logic       ks_n = 1'b1;
  logic       faster, slower;
  logic [1:0] held;

  always #5 clk = ~clk;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_RATE    (RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_faster_n(kf_n),
    .key_slower_n(ks_n),
    .faster      (faster),
    .slower      (slower),
    .held        (held)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: edge k is the clk edge that samples the inputs driven in cycle k;
  // outputs seen in cycle k+1 are the result of edge k.
  int         k = 0;
  int         t0 = 0;
  bit         m_valid = 0;
  bit   [1:0] m_p1, m_p2;      // pressed samples from the last two edges
  bit   [1:0] m_deb;           // debounced level
  int         m_run [2];       // consecutive samples disagreeing with m_deb
  bit   [1:0] m_active;        // key currently counted as pressed by the pulser
  int         m_next [2];      // edge of the next scheduled repeat, -1 if none
  bit         m_f, m_s;
  bit   [1:0] m_held;

  bit rec = 0;
  int fq[$];
  int sq[$];
  int first_held;
  int held_seen;

  function automatic void model_step(input bit rst, input bit [1:0] pressed);
    bit [1:0] s;
    bit [1:0] fire;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_deb = '0; m_active = '0;
      m_run[0] = 0; m_run[1] = 0; m_next[0] = -1; m_next[1] = -1;
      m_f = 0; m_s = 0; m_held = '0; m_valid = 1;
      return;
    end
    s = m_p2;
    m_p2 = m_p1;
    m_p1 = pressed;
    fire = '0;
    for (int i = 0; i < 2; i++) begin
      if (!m_active[i] && m_deb[i]) begin
        m_active[i] = 1;
        fire[i] = 1;
`ifdef KEY_PULSE_AUTO_REPEAT_EN
        m_next[i] = k + DLY;
`else
        m_next[i] = -1;
`endif
      end else if (m_active[i] && !m_deb[i]) begin
        m_active[i] = 0;
        m_next[i] = -1;
      end else if (m_active[i] && m_next[i] == k) begin
        fire[i] = 1;
        m_next[i] = k + RATE;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (s[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_held = m_deb;
    m_f = fire[1] & ~(m_deb[1] & m_deb[0]);
    m_s = fire[0] & ~(m_deb[1] & m_deb[0]) & ~fire[1];
  endfunction

  task automatic run_cycle(input bit rst, input bit kfn, input bit ksn);
    @(negedge clk);
    if (m_valid) begin
      check_eq("faster", {31'b0, faster}, {31'b0, m_f});
      check_eq("slower", {31'b0, slower}, {31'b0, m_s});
      check_eq("held", {30'b0, held}, {30'b0, m_held});
    end
    if (rec) begin
      if (faster === 1'b1) fq.push_back(k - t0);
      if (slower === 1'b1) sq.push_back(k - t0);
      if (held !== 2'b00) held_seen++;
      if (held[1] === 1'b1 && first_held < 0) first_held = k - t0;
    end
    reset = rst;
    kf_n  = kfn;
    ks_n  = ksn;
    model_step(rst, {~kfn, ~ksn});
    k++;
  endtask

  task automatic start_scenario();
    rec = 0;
    run_cycle(1, 1, 1);
    run_cycle(1, 1, 1);
    repeat (3) run_cycle(0, 1, 1);
    fq.delete();
    sq.delete();
    first_held = -1;
    held_seen = 0;
    t0 = k;
    rec = 1;
  endtask

  task automatic compare_list(input string tag, input int got[$], input int exp[$]);
    check_eq({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check_eq({tag, "_at"}, got[i], exp[i]);
    end
  endtask

  int exp_q[$];
  int empty_q[$];
  int rem [2];
  bit lvl [2];

  initial begin
    // long hold: first pulse, delay, then rate
    start_scenario();
    for (int i = 0; i < 100; i++) run_cycle(0, 0, 1);
    exp_q.delete();
    exp_q.push_back(7);
`ifdef KEY_PULSE_AUTO_REPEAT_EN
    for (int c = 7 + DLY; c <= 99; c += RATE) exp_q.push_back(c);
`endif
    compare_list("hold_faster", fq, exp_q);
    check_eq("hold_held_first", first_held, 6);
    repeat (10) run_cycle(0, 1, 1);

    // bounce shorter than the debounce window
    start_scenario();
    for (int i = 0; i < 40; i++) run_cycle(0, 1, ((i / 2) % 2) != 0);
    compare_list("bounce_slower", sq, empty_q);
    check_eq("bounce_held_cycles", held_seen, 0);

    // both keys held: only the first faster pulse survives
    start_scenario();
    for (int i = 0; i < 60; i++) run_cycle(0, 0, i < 10);
    exp_q.delete();
    exp_q.push_back(7);
    compare_list("both_faster", fq, exp_q);
    compare_list("both_slower", sq, empty_q);

    // reset in the middle of a hold restarts the press
    start_scenario();
    for (int i = 0; i < 61; i++) begin
      run_cycle(i == 30, 0, 1);
      if (i == 31) check_eq("reset_outputs", {29'b0, faster, slower, held}, 0);
    end
    exp_q.delete();
    exp_q.push_back(7);
`ifdef KEY_PULSE_AUTO_REPEAT_EN
    exp_q.push_back(27);
`endif
    exp_q.push_back(38);
`ifdef KEY_PULSE_AUTO_REPEAT_EN
    exp_q.push_back(58);
`endif
    compare_list("reset_faster", fq, exp_q);
    repeat (10) run_cycle(0, 1, 1);

    // release lands on the same edge as the repeat expiry
    start_scenario();
    for (int i = 0; i < 45; i++) run_cycle(0, i >= 28, 1);
    exp_q.delete();
    exp_q.push_back(7);
`ifdef KEY_PULSE_AUTO_REPEAT_EN
    exp_q.push_back(27);
`endif
    compare_list("race_faster", fq, exp_q);

    // random segments with bounce and occasional reset
    start_scenario();
    rec = 0;
    rem[0] = 0; rem[1] = 0; lvl[0] = 1; lvl[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (rem[j] == 0) begin
          lvl[j] = ~lvl[j];
          rem[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
        end
        rem[j]--;
      end
      run_cycle($urandom_range(0, 299) == 0, lvl[1], lvl[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000; consecutive stable cycles (10 ms at 50 MHz) needed to accept a key level change; legal minimum 2.
REQ-002 The module SHALL have parameter REPEAT_DELAY, default 25000000; cycles from the first pulse to the first auto-repeat pulse; legal minimum 2.
REQ-003 The module SHALL have parameter REPEAT_RATE, default 5000000; cycles between later auto-repeat pulses; legal minimum 2.
REQ-004 The module SHALL have port clk, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port key_faster_n, input, 1 bit: raw, asynchronous, active-low pushbutton.
REQ-007 The module SHALL have port key_slower_n, input, 1 bit: raw, asynchronous, active-low pushbutton.
REQ-008 The module SHALL have port faster, output, 1 bit: registered single-cycle request pulse for the delay controller.
REQ-009 The module SHALL have port slower, output, 1 bit: registered single-cycle request pulse for the delay controller.
REQ-010 The module SHALL have port held, output, 2 bits: debounced pressed state; bit 1 is faster and bit 0 is slower.

Function
REQ-011 Each key SHALL pass through its own 2-flop synchronizer and then be inverted; 1 means pressed.
REQ-012 Each key SHALL have a debounce counter that increments every cycle the synchronized level differs from the debounced level, and clears on any cycle they match.
REQ-013 When a debounce counter reaches DEBOUNCE_CYCLES consecutive differing cycles, the debounced level SHALL toggle and the counter SHALL clear on the same edge.
REQ-014 Each key SHALL have an FSM with states RELEASED, PRESSED and REPEATING.
REQ-015 RELEASED SHALL go to PRESSED on a debounced rising edge, emit one pulse, and load the repeat counter with REPEAT_DELAY.
REQ-016 PRESSED SHALL go to REPEATING when the repeat counter expires, emit one pulse, and load REPEAT_RATE.
REQ-017 REPEATING SHALL emit one pulse and reload REPEAT_RATE at each expiry.
REQ-018 PRESSED or REPEATING SHALL go to RELEASED on a debounced falling edge; a falling edge in the same cycle as an expiry SHALL win, with no pulse.
REQ-019 With no bounce, the first pulse SHALL be high exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples the key low.
REQ-020 Each pulse SHALL be high for exactly 1 cycle.
REQ-021 Pulses SHALL be spaced exactly REPEAT_DELAY cycles (first to second), then exactly REPEAT_RATE cycles.
REQ-022 Pulses SHALL be suppressed on both outputs in any cycle where both held bits are 1.
REQ-023 faster and slower SHALL never be high in the same cycle.
REQ-024 Pulses lost to suppression SHALL NOT be queued; the repeat timers keep running.
REQ-025 Each counter SHALL be ceil(log2(max count+1)) bits wide and SHALL never wrap.
REQ-026 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change on held.

Reset
REQ-027 While reset is high, faster, slower and held SHALL be 0.
REQ-028 While reset is high, both FSMs SHALL be RELEASED, all counters 0, and synchronizer flops 1 (released).
REQ-029 Reset SHALL take priority over all other activity, including mid-debounce and mid-repeat.
REQ-030 A key still held after reset deasserts SHALL be handled as a new press and pulse after DEBOUNCE_CYCLES+3 cycles.

Configuration
REQ-031 With macro KEY_PULSE_AUTO_REPEAT_EN defined, the REPEATING state, the repeat counters and REQ-016/017/021 SHALL be present.
REQ-032 Without KEY_PULSE_AUTO_REPEAT_EN, each FSM SHALL have only RELEASED and PRESSED, emit exactly one pulse per debounced press, and contain no repeat counters.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, macro defined unless noted)
REQ-033 Hold key_faster_n low from cycle 0 for 60 cycles -> faster pulses at cycles 7, 27, 35, 43, 51 and 59; held[1]=1 from cycle 6.
REQ-034 Toggle key_slower_n low/high every 2 cycles for 40 cycles -> slower stays 0 and held stays 0.
REQ-035 Press faster at cycle 0, press slower at cycle 10, hold both -> one faster pulse at 7, then no pulses on either output while both are held.
REQ-036 Hold faster, assert reset for 1 cycle at cycle 30, keep holding -> outputs are 0 during reset; faster pulses at 31+7=38, then at 58.
REQ-037 Macro undefined; hold key_faster_n low for 100 cycles -> exactly one faster pulse, at cycle 7.
REQ-038 Release a held key on the same cycle its repeat expiry would fire -> no pulse is emitted and the FSM returns to RELEASED.
